// File: rtl/rv_core_pkg.sv
// rv_core_pkg: shared opcodes, fetch FSM states and redirect kinds for the front end.
package rv_core_pkg;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    typedef enum logic [2:0] {S_RST, S_FETCH, S_WAIT, S_HOLD, S_DRAIN, S_TRAP} fetch_state_e;
    typedef enum logic [1:0] {RK_BRANCH, RK_JAL, RK_JALR, RK_RSVD} redir_kind_e;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: redirect target, redirect enable and misalignment detection.
module next_pc_calc
    import rv_core_pkg::*;
(
    input  redir_kind_e kind,
    input  logic        taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    output logic [31:0] target,
    output logic        do_redir,
    output logic        misaligned
);
    logic active;
    always_comb begin
        target     = kind == RK_JALR ? (rs1 + imm) & ~32'h1 : ex_pc + imm;
        active     = (kind == RK_BRANCH && taken) || kind == RK_JAL || kind == RK_JALR;
        // JALR clears bit 0, so checking both low bits covers every kind
        misaligned = active && target[1:0] != 2'b00;
        do_redir   = active && !misaligned;
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and single-outstanding instruction fetch toward decode,
// with branch/JAL/JALR redirects and a sticky misaligned-target trap.
module pc_fetch_unit
    import rv_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            redir_i,
    input  logic [1:0]      redir_kind_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_i,
    output logic            trap_o
);
    fetch_state_e    state, nxt;
    logic [XLEN-1:0] pc, pc_n, target;
    logic            do_redir, misaligned, redir, mis, live;

    next_pc_calc u_calc (
        .kind       (redir_kind_e'(redir_kind_i)),
        .taken      (br_taken_i),
        .ex_pc      (ex_pc_i),
        .imm        (imm_i),
        .rs1        (rs1_i),
        .target     (target),
        .do_redir   (do_redir),
        .misaligned (misaligned)
    );

    assign imem_req_o    = state == S_FETCH;
    assign imem_addr_o   = imem_req_o ? pc : '0;
    assign instr_valid_o = state == S_HOLD;

    always_comb begin
        live  = state inside {S_FETCH, S_WAIT, S_HOLD, S_DRAIN};
        redir = live && redir_i && do_redir;
        mis   = live && redir_i && misaligned;
        nxt   = state;
        pc_n  = pc;
        case (state)
            S_RST:   nxt = S_FETCH;
            // a grant in the redirect cycle was for the old pc, so its response must be drained
            S_FETCH: nxt = mis ? S_TRAP : redir ? (imem_gnt_i ? S_DRAIN : S_FETCH)
                                                : (imem_gnt_i ? S_WAIT : S_FETCH);
            S_WAIT:  nxt = mis ? S_TRAP : redir ? (imem_rvalid_i ? S_FETCH : S_DRAIN)
                                                : (imem_rvalid_i ? S_HOLD : S_WAIT);
            S_HOLD:  nxt = mis ? S_TRAP : (redir || instr_ready_i) ? S_FETCH : S_HOLD;
            S_DRAIN: nxt = mis ? S_TRAP : imem_rvalid_i ? S_FETCH : S_DRAIN;
            default: nxt = S_TRAP;
        endcase
        if (live && !mis)
            pc_n = redir ? target : (state == S_HOLD && instr_ready_i) ? pc + XLEN'(4) : pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_RST;
            pc      <= RESET_PC;
            instr_o <= '0;
            pc_o    <= '0;
            trap_o  <= 1'b0;
        end else begin
            state  <= nxt;
            pc     <= pc_n;
            trap_o <= nxt == S_TRAP;
            if (state == S_WAIT && nxt == S_HOLD) begin
                instr_o <= imem_rdata_i;
                pc_o    <= pc;
            end
        end
    end
endmodule
